mux41_select_arbiter: RTL and testbench
=======================================

// Module: mux41_select_arbiter
// PURPOSE
//  Round-robin arbiter that sits directly upstream of the 4:1 data mux and drives its 2-bit select.
//  Four sources raise requests; the block grants one at a time and holds select stable for the grant.
//  The grant lasts until the downstream consumer acknowledges that it has taken the mux output.
//  Priority rotates on every completed grant, so no source is starved.
// PARAMETERS
//  SEL_W           2   select width; fixed at 2, which gives four channels
//  N_CH            4   number of request channels; must equal 2**SEL_W
//  TIMEOUT_CYCLES  15  maximum GRANT cycles without ack; used only with ARB_TIMEOUT_EN
// PORTS
//  clk      in   1      single clock; everything is sampled on the rising edge
//  rst_n    in   1      asynchronous, active-low reset
//  req      in   4      per-channel request; bit i is a request from source i (mux input i+1)
//  ack      in   1      consumer has taken the current mux output
//  select   out  2      mux select; registered
//  grant    out  4      one-hot copy of select while valid; 4'b0000 otherwise
//  valid    out  1      select/grant are meaningful and held
//  timeout  out  1      one-cycle pulse when a grant is abandoned (ARB_TIMEOUT_EN only)
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous): outputs clear immediately.
//    - select=2'b00, grant=4'b0000, valid=0, timeout=0.
//    - Priority pointer ptr=0, state=IDLE, timeout counter=0.
//  - State machine has two states: IDLE and GRANT.
//  - IDLE:
//    - If req==0, stay in IDLE with outputs unchanged (select keeps its last value, valid=0).
//    - If req!=0, search ptr, ptr+1, ptr+2, ptr+3 (mod 4) and pick the first set bit k.
//    - On the next edge: select=k, grant=1<<k, valid=1, state=GRANT.
//    - Latency is one cycle from req sampled to valid.
//  - GRANT:
//    - select, grant and valid are held stable until ack=1 is sampled.
//    - If req[k] drops during GRANT, the grant is still held; withdrawing a request does not abort it.
//    - Changes on other req bits are ignored.
//    - On ack=1: next edge valid=0, grant=0, ptr=(k+1) mod 4 (wrap 3->0), state=IDLE.
//  - ack while in IDLE is ignored.
//  - Each grant costs one bubble cycle: at best one grant every 2 cycles.
//  - Simultaneous ack and a new req in the same cycle: the new req is arbitrated from IDLE on the next cycle.
//  - rst_n asserted mid-GRANT: the grant is dropped at once and ptr returns to 0.
// CONFIGURATION
//  - ARB_TIMEOUT_EN defined:
//    - A counter clears on entry to GRANT and increments every cycle in GRANT.
//    - If it reaches TIMEOUT_CYCLES with no ack: valid=0, grant=0, timeout=1 for exactly one cycle,
//      ptr=(k+1) mod 4, state=IDLE.
//    - An ack in the same cycle as expiry wins: a normal completion, no timeout pulse.
//  - ARB_TIMEOUT_EN undefined:
//    - No counter is built and timeout is tied to 0.
//    - GRANT waits indefinitely for ack.
// TESTING
//  1. Reset: hold rst_n=0 with random req -> select=00, grant=0000, valid=0, timeout=0.
//  2. Single request, held grant: req=0001, ack=0 for 5 cycles.
//     -> From cycle 1: select=00, grant=0001, valid=1, stable for all 5 cycles.
//     -> Then ack=1 for one cycle -> valid=0 on the next cycle.
//  3. Round robin: req=1111 held, ack=1 for one cycle whenever valid=1.
//     -> select sequence 00,01,10,11,00 with a single bubble between grants.
//  4. Pointer rotation: complete a grant to ch1, then req=0011.
//     -> ptr=2, so the search order is 2,3,0 -> select=00, grant=0001.
//  5. Reset mid-operation: rst_n=0 for 1 cycle while valid=1 on ch2.
//     -> valid=0 immediately.
//     -> Then req=1111 -> first grant is select=00.
//  6. Timeout, ARB_TIMEOUT_EN, TIMEOUT_CYCLES=15: req=0100, ack=0.
//     -> valid=1 for 15 cycles, then timeout=1 for one cycle with valid=0.
//     -> Then req=1100 -> select=11.
//     -> Without the macro, valid stays high for 100 cycles and timeout stays 0.

Source files
------------

// File: rtl/mux41_select_arbiter.sv
// Round-robin 4:1 mux-select arbiter; optional grant timeout via `ifdef ARB_TIMEOUT_EN.
// Latency: one cycle req->valid, one bubble after each grant; grant held until ack (or timeout).
module mux41_select_arbiter #(
    parameter int SEL_W          = 2,
    parameter int N_CH           = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  req,
    input  logic             ack,
    output logic [SEL_W-1:0] select,
    output logic [N_CH-1:0]  grant,
    output logic             valid,
    output logic             timeout
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    if (N_CH != (2 ** SEL_W) || TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("mux41_select_arbiter: N_CH must be 2**SEL_W and TIMEOUT_CYCLES >= 1");
    end

    logic [0:0]       state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] select_q, select_d;
    logic [N_CH-1:0]  grant_q, grant_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] pick;
    logic [SEL_W-1:0] idx;

    // Walk offsets from the far end so the nearest set bit to ptr wins.
    always_comb begin
        pick = ptr_q;
        idx  = ptr_q;
        for (int i = N_CH - 1; i >= 0; i--) begin
            idx = ptr_q + SEL_W'(i);
            if (req[idx]) pick = idx;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        select_d = select_q;
        grant_d  = grant_q;
        valid_d  = valid_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    select_d    = pick;
                    grant_d     = '0;
                    grant_d[pick] = 1'b1;
                    valid_d     = 1'b1;
                    state_d     = GRANT;
`ifdef ARB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            default: begin
                if (ack) begin
                    valid_d = 1'b0;
                    grant_d = '0;
                    ptr_d   = select_q + SEL_W'(1);
                    state_d = IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                // Ack on the expiry cycle takes the branch above: normal completion.
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    valid_d   = 1'b0;
                    grant_d   = '0;
                    ptr_d     = select_q + SEL_W'(1);
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            select_q <= '0;
            grant_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            select_q <= select_d;
            grant_q  <= grant_d;
            valid_q  <= valid_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign select = select_q;
    assign grant  = grant_q;
    assign valid  = valid_q;

endmodule

// File: tb/tb_mux41_select_arbiter.sv
// Directed bench for mux41_select_arbiter; expected values are hand-derived constants.
module tb_mux41_select_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       ack;
    logic [1:0] select;
    logic [3:0] grant;
    logic       valid;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    mux41_select_arbiter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .ack     (ack),
        .select  (select),
        .grant   (grant),
        .valid   (valid),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input string tag, input logic [1:0] s);
        logic [3:0] g;
        g = 4'b0001 << s;
        check({tag, "_valid"}, {31'd0, valid}, 32'd1);
        check({tag, "_select"}, {30'd0, select}, {30'd0, s});
        check({tag, "_grant"}, {28'd0, grant}, {28'd0, g});
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_valid"}, {31'd0, valid}, 32'd0);
        check({tag, "_grant"}, {28'd0, grant}, 32'd0);
    endtask

    logic [1:0] rr_seq [5];

    initial begin
        rr_seq[0] = 2'd0; rr_seq[1] = 2'd1; rr_seq[2] = 2'd2; rr_seq[3] = 2'd3; rr_seq[4] = 2'd0;
        rst_n = 1'b0;
        ack   = 1'b0;
        req   = 4'($urandom);

        // 1. reset with random requests
        for (int i = 0; i < 3; i++) begin
            req = 4'($urandom);
            tick();
        end
        check("rst_select", {30'd0, select}, 32'd0);
        expect_idle("rst");
        check("rst_timeout", {31'd0, timeout}, 32'd0);
        req   = 4'b0000;
        rst_n = 1'b1;
        tick();
        expect_idle("idle_noreq");

        // 2. single request held for 5 cycles
        req = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_grant($sformatf("hold%0d", i), 2'd0);
        end
        ack = 1'b1;
        req = 4'b0000;
        tick();
        expect_idle("hold_ack");
        ack = 1'b0;

        // 3. round robin from a fresh pointer
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            ack = 1'b0;
            tick();
            expect_grant($sformatf("rr%0d", k), rr_seq[k]);
            ack = 1'b1;
            tick();
            expect_idle($sformatf("rr_bubble%0d", k));
        end
        ack = 1'b0;
        req = 4'b0000;
        tick();

        // 4. pointer rotation: ch1 done -> ptr=2, req=0011 -> ch0
        req = 4'b0010;
        tick();
        expect_grant("rot_ch1", 2'd1);
        ack = 1'b1;
        req = 4'b0000;
        tick();
        expect_idle("rot_done");
        ack = 1'b0;
        req = 4'b0011;
        tick();
        expect_grant("rot_wrap", 2'd0);
        req = 4'b0000;
        tick();
        expect_grant("rot_drop_held", 2'd0);
        ack = 1'b1;
        tick();
        ack = 1'b0;

        // 5. reset while granting ch2
        req = 4'b0100;
        tick();
        expect_grant("mid_ch2", 2'd2);
        rst_n = 1'b0;
        #1;
        expect_idle("mid_rst_async");
        check("mid_rst_select", {30'd0, select}, 32'd0);
        tick();
        rst_n = 1'b1;
        req = 4'b1111;
        tick();
        expect_grant("post_rst", 2'd0);
        ack = 1'b1;
        req = 4'b0000;
        tick();
        ack = 1'b0;

        // 6. no ack on ch2
        req = 4'b0100;
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            tick();
            check($sformatf("to_valid%0d", i), {31'd0, valid}, 32'd1);
            check($sformatf("to_pulse%0d", i), {31'd0, timeout}, 32'd0);
        end
        req = 4'b1100;
        tick();
        expect_idle("to_expire");
        check("to_pulse", {31'd0, timeout}, 32'd1);
        tick();
        expect_grant("to_next", 2'd3);
        check("to_pulse_clear", {31'd0, timeout}, 32'd0);
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            check($sformatf("nto_valid%0d", i), {31'd0, valid}, 32'd1);
            check($sformatf("nto_pulse%0d", i), {31'd0, timeout}, 32'd0);
        end
        expect_grant("nto_sel", 2'd2);
        ack = 1'b1;
        req = 4'b1100;
        tick();
        expect_idle("nto_ack");
        ack = 1'b0;
        tick();
        expect_grant("nto_next", 2'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
